// File: rtl/char_rom_seq.sv
// char_rom_seq: two-client round-robin glyph fetch sequencer.
// Each grant issues 32 consecutive font-ROM line addresses. Every line read
// back from the ROM is registered and returned with one cycle of latency.
module char_rom_seq #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LINES      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [5:0]            char_number0,
  input  logic [5:0]            char_number1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [5:0]            rom_char_number,
  output logic [4:0]            rom_char_line,
  input  logic [DATA_WIDTH-1:0] rom_line_data,
  output logic [DATA_WIDTH-1:0] line_data,
  output logic [4:0]            line_idx,
  output logic                  line_valid,
  output logic                  line_owner,
  output logic                  burst_done,
  output logic                  busy
);

  localparam int unsigned LINE_W = 5;
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t state, state_nxt;
  logic   last_gnt;     // client granted most recently; the other one wins a tie
  logic   owner;        // client that owns the burst currently issuing addresses
  logic   decision;
  logic   gnt0, gnt1;

  assign busy = (state == BURST);

  // Next state and arbitration; a grant is only possible at a decision point
  always_comb begin
    state_nxt = state;
    decision  = (state == IDLE) || (rom_char_line == LAST_LINE);
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    if (decision) begin
      gnt0 = req0 && (!req1 || last_gnt);
      gnt1 = req1 && (!req0 || !last_gnt);
    end
    case (state)
      IDLE:    if (gnt0 || gnt1) state_nxt = BURST;
      BURST:   if ((rom_char_line == LAST_LINE) && !(gnt0 || gnt1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, address generation and one-stage read pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      last_gnt        <= 1'b1;
      owner           <= 1'b0;
      ack0            <= 1'b0;
      ack1            <= 1'b0;
      rom_char_number <= '0;
      rom_char_line   <= '0;
      line_data       <= '0;
      line_idx        <= '0;
      line_valid      <= 1'b0;
      line_owner      <= 1'b0;
      burst_done      <= 1'b0;
    end else begin
      state <= state_nxt;
      ack0  <= gnt0;
      ack1  <= gnt1;
      if (gnt0 || gnt1) begin
        rom_char_number <= gnt1 ? char_number1 : char_number0;
        rom_char_line   <= '0;
        owner           <= gnt1;
        last_gnt        <= gnt1;
      end else if (busy && (rom_char_line != LAST_LINE)) begin
        rom_char_line <= rom_char_line + LINE_W'(1);
      end
      // The line returned this cycle belongs to the address issued last cycle
      line_valid <= busy;
      burst_done <= busy && (rom_char_line == LAST_LINE);
      if (busy) begin
        line_data  <= rom_line_data;
        line_idx   <= rom_char_line;
        line_owner <= owner;
      end
    end
  end

endmodule
